hopfield_control: RTL and testbench

Controller FSM for the Hopfield network datapath. It sequences three phases: loading a new input pattern into the neurons, iteratively updating neuron states until convergence, and a one-cycle weight-learning phase. It drives the neuron-update and weight-update enables from datapath status flags.

---
 rtl/hopfield_control.sv | 72 +++++++
 tb/tb_hopfield_control.sv | 124 ++++++++++++
 2 files changed

// File: rtl/hopfield_control.sv
// Sequencing controller for the Hopfield datapath: it loads a new input pattern,
// iterates neuron updates until they converge, then runs one weight-learning cycle.
module hopfield_control #(
  parameter logic [1:0] STATE_INPUT    = 2'd0,
  parameter logic [1:0] STATE_UPDATING = 2'd1,
  parameter logic [1:0] STATE_LEARNING = 2'd2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       same_input,
  input  logic       converged,
  output logic       modify_neuron,
  output logic       modify_neuron_using_input,
  output logic       modify_weights,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_INPUT    = STATE_INPUT,
    ST_UPDATING = STATE_UPDATING,
    ST_LEARNING = STATE_LEARNING
  } state_e;

  state_e state_q;
  state_e state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INPUT;
    end else begin
      state_q <= state_d;
    end
  end

  // Flags are compared against 1 so that an X or Z flag falls into the
  // deasserted branch; a changed input always abandons the current update.
  always_comb begin
    state_d                   = state_q;
    modify_neuron             = 1'b0;
    modify_neuron_using_input = 1'b0;
    modify_weights            = 1'b0;
    case (state_q)
      ST_INPUT: begin
        modify_neuron             = 1'b1;
        modify_neuron_using_input = 1'b1;
        if (same_input == 1'b1) begin
          state_d = ST_UPDATING;
        end
      end
      ST_UPDATING: begin
        modify_neuron = 1'b1;
        if (same_input == 1'b1) begin
          if (converged == 1'b1) begin
            state_d = ST_LEARNING;
          end
        end else begin
          state_d = ST_INPUT;
        end
      end
      ST_LEARNING: begin
        modify_weights = 1'b1;
        state_d        = ST_INPUT;
      end
      default: begin
        state_d = ST_INPUT;
      end
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_hopfield_control.sv
// Self-checking bench for hopfield_control: directed phase walks followed by
// randomized flag traffic compared against a phase-level reference model.
module tb_hopfield_control;

  logic       clk;
  logic       rst;
  logic       sameInput;
  logic       converged;
  logic       modifyNeuron;
  logic       modifyNeuronUsingInput;
  logic       modifyWeights;
  logic [1:0] stateOut;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: phase 0 = load input, 1 = update neurons, 2 = learn weights.
  int modelPhase = 0;
  int learnCount = 0;

  hopfield_control dut (
    .clk                       (clk),
    .rst                       (rst),
    .same_input                (sameInput),
    .converged                 (converged),
    .modify_neuron             (modifyNeuron),
    .modify_neuron_using_input (modifyNeuronUsingInput),
    .modify_weights            (modifyWeights),
    .state                     (stateOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nextPhase(int phase, logic r, logic si, logic cv);
    bit newPattern;
    bit settled;
    newPattern = !(si === 1'b1);
    settled    = (cv === 1'b1);
    if (r === 1'b1) return 0;
    if (phase == 0) return newPattern ? 0 : 1;
    if (phase == 1) begin
      if (newPattern) return 0;
      return settled ? 2 : 1;
    end
    return 0;
  endfunction

  // Expected {state, modify_neuron, modify_neuron_using_input, modify_weights}.
  function automatic logic [4:0] expectedOutputs(int phase);
    logic [2:0] enables [3];
    enables[0] = 3'b110;
    enables[1] = 3'b100;
    enables[2] = 3'b001;
    return {phase[1:0], enables[phase]};
  endfunction

  task automatic checkOutput(input string tag, input logic [4:0] observed,
                             input logic [4:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed state/mn/mnui/mw=%b required %b", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic si, input logic cv, input string tag);
    rst       = r;
    sameInput = si;
    converged = cv;
    @(posedge clk);
    modelPhase = nextPhase(modelPhase, r, si, cv);
    if (modelPhase == 2) learnCount++;
    #1;
    checkOutput(tag, {stateOut, modifyNeuron, modifyNeuronUsingInput, modifyWeights},
                expectedOutputs(modelPhase));
  endtask

  initial begin
    int learnBefore;
    rst       = 1'b1;
    sameInput = 1'b0;
    converged = 1'b0;
    @(negedge clk);

    applyStimulus(1'b1, 1'b0, 1'b0, "reset");
    applyStimulus(1'b0, 1'b0, 1'b0, "holdInput0");
    applyStimulus(1'b0, 1'bx, 1'b1, "holdInputX");
    applyStimulus(1'b0, 1'b0, 1'b1, "ignoreConvergedInInput");
    applyStimulus(1'b0, 1'b1, 1'b1, "bothFlagsInInput");
    applyStimulus(1'b0, 1'b1, 1'b0, "stayUpdating1");
    applyStimulus(1'b0, 1'b1, 1'b0, "stayUpdating2");
    applyStimulus(1'b0, 1'b1, 1'bx, "stayUpdatingX");
    applyStimulus(1'b0, 1'b1, 1'b1, "toLearning");
    applyStimulus(1'b0, 1'b1, 1'b1, "learningToInput");

    applyStimulus(1'b0, 1'b1, 1'b0, "toUpdatingAgain");
    learnBefore = learnCount;
    applyStimulus(1'b0, 1'b0, 1'b1, "abortPriority");
    checkOutput("noLearningOnAbort", 5'(learnCount - learnBefore), 5'd0);

    applyStimulus(1'b0, 1'b1, 1'b0, "toUpdating3");
    applyStimulus(1'b0, 1'bx, 1'b0, "abortOnXInput");
    applyStimulus(1'b0, 1'b1, 1'b0, "toUpdating4");
    applyStimulus(1'b1, 1'b1, 1'b1, "resetMidUpdating");
    applyStimulus(1'b0, 1'b1, 1'b0, "toUpdating5");
    applyStimulus(1'b0, 1'b1, 1'b1, "toLearning2");
    applyStimulus(1'b1, 1'b1, 1'b1, "resetMidLearning");

    for (int i = 0; i < 400; i++) begin
      logic r;
      logic si;
      logic cv;
      r  = ($urandom_range(0, 15) == 0);
      si = ($urandom_range(0, 3) != 0);
      cv = ($urandom_range(0, 2) == 0);
      applyStimulus(r, si, cv, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
